// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, PSLVERR encodings and default bus widths.
package apb_pkg;

  localparam int unsigned ApbAddrWidth = 32;
  localparam int unsigned ApbDataWidth = 32;

  localparam logic PslverrOkay  = 1'b0;
  localparam logic PslverrError = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Register storage: one synchronous write port, one combinational read port.
// Word 0 is never written, so it always reads back as zero here; the bank
// substitutes its ID value for that word.
module apb_regfile #(
  parameter int unsigned Depth     = 16,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned IdxW     = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [IdxW-1:0]      waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [IdxW-1:0]      raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  // Asynchronous clear of every word; writes to word 0 are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with a small register bank, a read-only ID word at offset 0 and a
// configurable number of wait states before each access cycle.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = ApbAddrWidth,
  parameter int unsigned           DATA_WIDTH  = ApbDataWidth,
  parameter int unsigned           DEPTH       = 16,
  parameter int unsigned           WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA5B0_0001)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  // A zero-wait build never uses the counter; keep it one bit wide so it stays legal.
  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntInit = (WAIT_CYCLES > 0) ? CntW'(WAIT_CYCLES - 1) : '0;

  apb_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;

  logic [IdxW-1:0]       idx;
  logic                  upper_err;
  logic                  err;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  assign idx       = addr_q[IdxW+1:2];
  assign upper_err = |(addr_q >> (IdxW + 2));
  assign err       = (addr_q[1:0] != 2'b00) || upper_err || (write_q && (idx == '0));

  // Transfer-tracking state; reset abandons any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

  // Next state: setup latches the request, WAIT counts down, ACCESS lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    unique case (state_q)
      StIdle: begin
        // PENABLE without a setup cycle is not a transfer.
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = CntInit;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StWait: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAccess: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Bus outputs and write strobe, all qualified by the ACCESS cycle.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = PslverrOkay;
    PRDATA  = '0;
    we      = 1'b0;
    if (state_q == StAccess) begin
      PREADY  = 1'b1;
      PSLVERR = err ? PslverrError : PslverrOkay;
      if (!err) begin
        if (write_q) begin
          we = 1'b1;
        end else begin
          PRDATA = (idx == '0) ? ID_VALUE : rdata;
        end
      end
    end
  end

  apb_regfile #(
    .Depth    (DEPTH),
    .DataWidth(DATA_WIDTH)
  ) u_regfile (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .we_i   (we),
    .waddr_i(idx),
    .wdata_i(PWDATA),
    .raddr_i(idx),
    .rdata_o(rdata)
  );

endmodule

// File: doc/apb_slave_regbank.md
APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: PADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: PWDATA/PRDATA width.
REQ-003 SHALL have parameter DEPTH, default 16: number of 32-bit words, a power of two, at least 2.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1: number of wait states per transfer, 0 to 15.
REQ-005 SHALL have parameter ID_VALUE, default 32'hA5B0_0001: read-only contents of word 0.
REQ-006 SHALL have ports HCLK (in, 1, clock) and HRESETn (in, 1, reset). The block uses one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port PSEL (in, 1): slave select.
REQ-008 SHALL have port PENABLE (in, 1): access phase.
REQ-009 SHALL have port PADDR (in, ADDR_WIDTH): byte address.
REQ-010 SHALL have port PWRITE (in, 1): 1 = write, 0 = read.
REQ-011 SHALL have port PWDATA (in, DATA_WIDTH): write data.
REQ-012 SHALL have port PRDATA (out, DATA_WIDTH): read data.
REQ-013 SHALL have port PREADY (out, 1): transfer completes this cycle.
REQ-014 SHALL have port PSLVERR (out, 1): transfer error, qualified by PREADY.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and ACCESS, plus a wait counter of width $clog2(WAIT_CYCLES+1).
REQ-016 IDLE: PSEL=1 and PENABLE=0 (setup cycle) SHALL latch PADDR and PWRITE. The next state SHALL be WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise ACCESS.
REQ-017 IDLE: PENABLE=1 without a preceding setup cycle SHALL be ignored (stay IDLE, no write).
REQ-018 WAIT: the counter SHALL decrement each cycle. At counter=0 the next state SHALL be ACCESS.
REQ-019 In WAIT, PSEL=0 (aborted transfer) SHALL return the FSM to IDLE with no register update.
REQ-020 ACCESS SHALL be one cycle long and SHALL always be followed by IDLE, so the next setup cycle overlaps IDLE and back-to-back transfers have no bubble.
REQ-021 PREADY SHALL be 1 only in ACCESS. PREADY=0 in IDLE and WAIT.
REQ-022 PREADY SHALL rise exactly WAIT_CYCLES+1 cycles after the setup cycle.
REQ-023 The word index SHALL be latched PADDR[$clog2(DEPTH)+1:2].
REQ-024 The error condition SHALL be true for any of:
- PADDR[1:0] != 0;
- any PADDR bit at or above $clog2(DEPTH)+2 set;
- a write to word 0.
REQ-025 PSLVERR SHALL equal the error condition in ACCESS and SHALL be 0 otherwise.
REQ-026 A write SHALL commit PWDATA (sampled in ACCESS) on the ACCESS clock edge, only when the error condition is false.
REQ-027 An errored write SHALL leave storage unchanged.
REQ-028 PRDATA SHALL be the addressed word in ACCESS for a non-error read: ID_VALUE for word 0, storage otherwise.
REQ-029 PRDATA SHALL be 0 in all other cases, including errored reads and writes.

Reset
REQ-030 HRESETn low SHALL immediately force state=IDLE, counter=0, latched address/PWRITE=0 and all writable words=0, including in the middle of a transfer.
REQ-031 During reset, outputs SHALL be PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-032 A transfer interrupted by reset SHALL NOT commit.

Structure
REQ-033 Package apb_pkg SHALL hold:
- the FSM state enum (IDLE, WAIT, ACCESS);
- the PSLVERR OKAY/ERROR constants;
- the ADDR_WIDTH/DATA_WIDTH defaults shared with the bridge.
REQ-034 Storage SHALL be the sub-module apb_regfile: DEPTH words with one synchronous write port and one combinational read port, words 1..DEPTH-1 writable, and asynchronous clear.

Verification
REQ-035 Reset release, then read 0x00 with WAIT_CYCLES=1 -> PREADY high 2 cycles after setup, PRDATA=32'hA5B0_0001, PSLVERR=0.
REQ-036 Write 0x04=32'hDEAD_BEEF, then back-to-back read 0x04 -> read completes 2 cycles after its setup, PRDATA=32'hDEAD_BEEF, no idle bubble between the transfers.
REQ-037 Write 0x00, write 0x41 and write 0x40 (each with PWDATA=32'h1234_5678) -> PSLVERR=1 with PREADY for each. A later read of 0x00 returns ID_VALUE.
REQ-038 WAIT_CYCLES=0 build: read 0x08 after writing 32'h55 -> PREADY high in the first access cycle, PRDATA=32'h55.
REQ-039 Write 0x0C=32'hCAFE, assert HRESETn=0 in the WAIT cycle -> PREADY stays 0, and a read of 0x0C after reset returns 0.
REQ-040 Deassert PSEL during WAIT on a write to 0x10 -> FSM returns to IDLE, and a later read of 0x10 returns 0.
